// File: rtl/hall_sensor_decoder.sv
// hall_sensor_decoder
// Synchronizes and glitch-filters three raw Hall inputs, then decodes the
// commutation sector, rotation direction and inter-edge period. Illegal codes,
// skipped sectors and stalls are flagged.
// Optional feature macro: HALL_DEC_ERROR_COUNT_EN builds the 8-bit saturating
// error counter; without it error_count is tied to zero.
module hall_sensor_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          hall_in,
  input  logic [15:0]         glitch_cycles,
  input  logic [PERIOD_W-1:0] stall_timeout,
  output logic [2:0]          sector,
  output logic                hall_valid,
  output logic                direction,
  output logic                dir_valid,
  output logic                edge_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic                hall_error,
  output logic [7:0]          error_count
);

  localparam logic [PERIOD_W-1:0] P_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] P_MAX = {PERIOD_W{1'b1}};
  localparam logic [2:0]          SEC_INVALID = 3'd7;

  // Forward order 011,010,110,100,101,001 maps to sectors 0..5.
  function automatic logic [2:0] code_to_sector(input logic [2:0] code);
    case (code)
      3'b011:  code_to_sector = 3'd0;
      3'b010:  code_to_sector = 3'd1;
      3'b110:  code_to_sector = 3'd2;
      3'b100:  code_to_sector = 3'd3;
      3'b101:  code_to_sector = 3'd4;
      3'b001:  code_to_sector = 3'd5;
      default: code_to_sector = SEC_INVALID;
    endcase
  endfunction

  logic [3*SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]               sync_code;
  logic [2:0]               cand_q, cand_d;
  logic [15:0]              gcnt_q, gcnt_d;
  logic [2:0]               acc_q, acc_d;
  logic [PERIOD_W-1:0]      pcnt_q, pcnt_d, pcnt_inc;
  logic                     ref_q, ref_d;
  logic [2:0]               sector_q, sector_d;
  logic                     hall_valid_q, hall_valid_d;
  logic                     direction_q, direction_d;
  logic                     dir_valid_q, dir_valid_d;
  logic                     edge_strobe_q, edge_strobe_d;
  logic [PERIOD_W-1:0]      period_q, period_d;
  logic                     period_valid_q, period_valid_d;
  logic                     stalled_q, stalled_d;
  logic                     hall_error_q, hall_error_d;
  logic                     accept;
  logic [2:0]               new_sec, old_sec;
  logic [3:0]               dsum, diff;

  // Shift raw inputs through the synchronizer; oldest stage is the usable code.
  always_comb begin
    sync_d    = {sync_q[3*SYNC_STAGES-4:0], hall_in};
    sync_code = sync_q[3*SYNC_STAGES-1 -: 3];
  end

  // Filter, acceptance, sector/direction decode, period and stall tracking.
  always_comb begin
    cand_d         = cand_q;
    gcnt_d         = gcnt_q;
    acc_d          = acc_q;
    pcnt_d         = pcnt_q;
    ref_d          = ref_q;
    sector_d       = sector_q;
    hall_valid_d   = hall_valid_q;
    direction_d    = direction_q;
    dir_valid_d    = dir_valid_q;
    edge_strobe_d  = 1'b0;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    stalled_d      = stalled_q;
    hall_error_d   = 1'b0;

    new_sec  = code_to_sector(cand_q);
    old_sec  = code_to_sector(acc_q);
    dsum     = {1'b0, new_sec} + 4'd6 - {1'b0, old_sec};
    diff     = (dsum >= 4'd6) ? (dsum - 4'd6) : dsum;
    pcnt_inc = (pcnt_q == P_MAX) ? pcnt_q : (pcnt_q + P_ONE);
    accept   = enable && (cand_q != acc_q) && (gcnt_q >= glitch_cycles);

    if (enable) begin
      if (sync_code != cand_q) begin
        cand_d = sync_code;
        gcnt_d = 16'd0;
      end else if (gcnt_q != 16'hFFFF) begin
        gcnt_d = gcnt_q + 16'd1;
      end
    end

    if (!enable) begin
      pcnt_d         = '0;
      stalled_d      = 1'b0;
      dir_valid_d    = 1'b0;
      period_valid_d = 1'b0;
      ref_d          = 1'b0;
    end else if (accept) begin
      // An accept always restarts the measurement and overrides a stall.
      acc_d     = cand_q;
      pcnt_d    = '0;
      stalled_d = 1'b0;
      if (new_sec == SEC_INVALID) begin
        sector_d       = SEC_INVALID;
        hall_valid_d   = 1'b0;
        dir_valid_d    = 1'b0;
        period_valid_d = 1'b0;
        hall_error_d   = 1'b1;
        ref_d          = 1'b0;
      end else if (old_sec == SEC_INVALID) begin
        sector_d     = new_sec;
        hall_valid_d = 1'b1;
        ref_d        = 1'b1;
      end else begin
        sector_d     = new_sec;
        hall_valid_d = 1'b1;
        if ((diff == 4'd1) || (diff == 4'd5)) begin
          direction_d   = (diff == 4'd5);
          dir_valid_d   = 1'b1;
          edge_strobe_d = 1'b1;
          if (ref_q && !stalled_q) begin
            period_d       = pcnt_inc;
            period_valid_d = 1'b1;
          end
          ref_d = 1'b1;
        end else begin
          hall_error_d   = 1'b1;
          dir_valid_d    = 1'b0;
          period_valid_d = 1'b0;
          ref_d          = 1'b0;
        end
      end
    end else begin
      pcnt_d = pcnt_inc;
      if ((stall_timeout != '0) && (pcnt_inc >= stall_timeout)) begin
        stalled_d      = 1'b1;
        period_valid_d = 1'b0;
        dir_valid_d    = 1'b0;
        ref_d          = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      cand_q         <= 3'b000;
      gcnt_q         <= 16'd0;
      acc_q          <= 3'b000;
      pcnt_q         <= '0;
      ref_q          <= 1'b0;
      sector_q       <= SEC_INVALID;
      hall_valid_q   <= 1'b0;
      direction_q    <= 1'b0;
      dir_valid_q    <= 1'b0;
      edge_strobe_q  <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      hall_error_q   <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      cand_q         <= cand_d;
      gcnt_q         <= gcnt_d;
      acc_q          <= acc_d;
      pcnt_q         <= pcnt_d;
      ref_q          <= ref_d;
      sector_q       <= sector_d;
      hall_valid_q   <= hall_valid_d;
      direction_q    <= direction_d;
      dir_valid_q    <= dir_valid_d;
      edge_strobe_q  <= edge_strobe_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      hall_error_q   <= hall_error_d;
    end
  end

`ifdef HALL_DEC_ERROR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of error pulses.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (hall_error_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign error_count = err_cnt_q;
`else
  assign error_count = 8'd0;
`endif

  assign sector       = sector_q;
  assign hall_valid   = hall_valid_q;
  assign direction    = direction_q;
  assign dir_valid    = dir_valid_q;
  assign edge_strobe  = edge_strobe_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign hall_error   = hall_error_q;

endmodule
